vga_timing_gen: RTL and testbench

Consumes the pixel-rate strobe produced by the enable generator and turns it into VGA raster timing. It outputs the horizontal and vertical counters, the hsync and vsync pulses, the display-enable signal and a frame-start strobe. It sits between the enable generator and the pixel/colour pipeline. All state advances only on clock edges where the enable strobe is high.

---
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from a pixel-rate strobe (counters, syncs, DE, frame start).
// Ports: clk/i_rst (async, active-high)/i_sclr (sync clear)/i_en (pixel strobe) in;
//        o_x/o_y counters, o_hsync/o_vsync, o_de, o_frame_start out. All outputs registered.
// Latency: one clk from an enabled edge to updated outputs; no backpressure, i_en gaps only stretch time.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_sclr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_de,
   output logic             o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ACT = (SYNC_POL != 0);

   logic [CNT_W-1:0] x_q, y_q;
   logic [CNT_W-1:0] x_d, y_d;
   logic             hs_q, vs_q, de_q, fs_q;
   logic             hs_d, vs_d, de_d, fs_d;

   // Advanced raster position, used only on enabled edges. Level outputs are
   // decoded from this next position so they line up with the registered counters.
   always_comb begin
      x_d  = x_q + CNT_W'(1);
      y_d  = y_q;
      fs_d = 1'b0;
      if (x_q == H_LAST) begin
         x_d = '0;
         if (y_q == V_LAST) begin
            y_d  = '0;
            fs_d = 1'b1;
         end else begin
            y_d = y_q + CNT_W'(1);
         end
      end
      hs_d = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vs_d = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      de_d = (x_d < H_VIS) && (y_d < V_VIS);
   end

   // Cleared state is position (0,0): visible, syncs idle, no frame-start pulse.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         x_q  <= '0;
         y_q  <= '0;
         hs_q <= ~SYNC_ACT;
         vs_q <= ~SYNC_ACT;
         de_q <= 1'b1;
         fs_q <= 1'b0;
      end else if (i_sclr) begin
         x_q  <= '0;
         y_q  <= '0;
         hs_q <= ~SYNC_ACT;
         vs_q <= ~SYNC_ACT;
         de_q <= 1'b1;
         fs_q <= 1'b0;
      end else if (i_en) begin
         x_q  <= x_d;
         y_q  <= y_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
         fs_q <= fs_d;
      end else begin
         fs_q <= 1'b0;
      end
   end

   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_hsync       = hs_q;
   assign o_vsync       = vs_q;
   assign o_de          = de_q;
   assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen with a tiny 8x6 raster.
// Drives inputs and samples outputs on the falling edge; DUT acts on the rising edge.
// Expected values come from hand-written raster rules for the small geometry.
module tb_vga_timing_gen;

   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             i_rst;
   logic             i_sclr;
   logic             i_en;
   logic [CNT_W-1:0] o_x, o_y;
   logic             o_hsync, o_vsync, o_de, o_frame_start;

   int checks = 0;
   int errors = 0;
   int ex = 0;
   int ey = 0;

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(0), .CNT_W(CNT_W)
   ) dut (
      .clk           (clk),
      .i_rst         (i_rst),
      .i_sclr        (i_sclr),
      .i_en          (i_en),
      .o_x           (o_x),
      .o_y           (o_y),
      .o_hsync       (o_hsync),
      .o_vsync       (o_vsync),
      .o_de          (o_de),
      .o_frame_start (o_frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then return on the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Raster advance for 8 pixels x 6 lines.
   task automatic adv();
      ex++;
      if (ex == 8) begin
         ex = 0;
         ey++;
         if (ey == 6) ey = 0;
      end
   endtask

   // Level outputs for the small raster: visible x<4,y<3; hsync low x=5,6; vsync low y=4.
   task automatic check_pos(input string tag, input logic efs);
      check({tag, ".x"},  32'(o_x), 32'(ex));
      check({tag, ".y"},  32'(o_y), 32'(ey));
      check({tag, ".de"}, 32'(o_de), 32'((ex < 4) && (ey < 3)));
      check({tag, ".hs"}, 32'(o_hsync), 32'(!((ex == 5) || (ex == 6))));
      check({tag, ".vs"}, 32'(o_vsync), 32'(ey != 4));
      check({tag, ".fs"}, 32'(o_frame_start), 32'(efs));
   endtask

   initial begin
      int fs_cnt;
      int vs_cnt;

      // Reset state.
      i_rst  = 1'b1;
      i_sclr = 1'b0;
      i_en   = 1'b0;
      @(negedge clk);
      check_pos("reset", 1'b0);
      i_rst = 1'b0;

      // Strobe low: counters hold.
      step();
      step();
      check_pos("hold", 1'b0);

      // Line scan then three full frames with i_en tied high.
      i_en   = 1'b1;
      fs_cnt = 0;
      vs_cnt = 0;
      for (int k = 1; k <= 144; k++) begin
         step();
         adv();
         check_pos("scan", (ex == 0) && (ey == 0));
         if (o_frame_start) fs_cnt++;
         if (!o_vsync) vs_cnt++;
         if (k == 8) begin
            check("line_wrap.x", 32'(o_x), 32'd0);
            check("line_wrap.y", 32'(o_y), 32'd1);
         end
      end
      check("scan_fs_count", 32'(fs_cnt), 32'd3);
      check("scan_vs_clks", 32'(vs_cnt), 32'd24);

      // Gated strobe: one pulse every 8 clks, 48 pulses = one frame in 384 clks.
      fs_cnt = 0;
      for (int c = 0; c < 384; c++) begin
         i_en = ((c % 8) == 7);
         step();
         if (i_en) adv();
         check_pos("gated", i_en && (ex == 0) && (ey == 0));
         if (o_frame_start) fs_cnt++;
      end
      i_en = 1'b0;
      check("gated_fs_count", 32'(fs_cnt), 32'd1);
      check("gated_end.x", 32'(o_x), 32'd0);
      check("gated_end.y", 32'(o_y), 32'd0);

      // Synchronous clear at (6,2) with i_en high on the same edge.
      i_en = 1'b1;
      for (int k = 0; k < 22; k++) begin
         step();
         adv();
      end
      check_pos("pre_sclr", 1'b0);
      check("pre_sclr.x6", 32'(o_x), 32'd6);
      i_sclr = 1'b1;
      step();
      i_sclr = 1'b0;
      ex = 0;
      ey = 0;
      check_pos("sclr", 1'b0);
      step();
      adv();
      check_pos("post_sclr", 1'b0);
      check("post_sclr.x1", 32'(o_x), 32'd1);

      // Asynchronous reset mid-frame at (3,4) while vsync is active.
      for (int k = 0; k < 34; k++) begin
         step();
         adv();
      end
      check("pre_rst.x", 32'(o_x), 32'd3);
      check("pre_rst.y", 32'(o_y), 32'd4);
      check("pre_rst.vs", 32'(o_vsync), 32'd0);
      i_rst = 1'b1;
      #1;
      ex = 0;
      ey = 0;
      check_pos("async_rst", 1'b0);
      i_en = 1'b0;
      step();
      i_rst = 1'b0;
      i_en  = 1'b1;
      step();
      adv();
      check_pos("post_rst", 1'b0);
      fs_cnt = 0;
      for (int k = 2; k <= 47; k++) begin
         step();
         adv();
         if (o_frame_start) fs_cnt++;
      end
      check("post_rst_no_fs", 32'(fs_cnt), 32'd0);
      step();
      adv();
      check_pos("post_rst_wrap", 1'b1);
      i_en = 1'b0;
      step();
      check("fs_one_clk", 32'(o_frame_start), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
